// File: rtl/dram_row_sequencer_if.sv
// Request/response handshake between the AXI slave wrapper and the DRAM row sequencer.
// The sequencer uses the slave modport and the wrapper uses the master modport.
interface dram_row_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dram_row_sequencer.sv
// Single-word open-page DRAM command scheduler: tracks one open row and issues PRE/ACT/RD/WR
// with parameterised NOP gaps. Every output is a flop decoded from the next state.
module dram_row_sequencer #(
    parameter int unsigned T_RP  = 4,
    parameter int unsigned T_RCD = 4,
    parameter int unsigned T_WR  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    dram_row_sequencer_if.slave        bus,
    output logic                       row_open,
    output logic                       DRAM_CSn,
    output logic [3:0]                 DRAM_WEn,
    output logic                       DRAM_RASn,
    output logic                       DRAM_CASn,
    output logic [10:0]                DRAM_A,
    output logic [31:0]                DRAM_D,
    input  logic                       DRAM_valid,
    input  logic [31:0]                DRAM_Q
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_PWAIT, S_ACT, S_AWAIT, S_RD, S_RWAIT, S_WR, S_WWAIT, S_RSP
    } state_t;

    localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);
    localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
    localparam logic [3:0] WR_LOAD  = 4'(T_WR - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [10:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        row_open_q, row_open_d;
    logic [10:0] open_row_q, open_row_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        req_ready_q, req_ready_d;
    logic        csn_q, csn_d, rasn_q, rasn_d, casn_q, casn_d;
    logic [3:0]  wen_q, wen_d;
    logic [10:0] a_q, a_d;
    logic [31:0] d_q, d_d;
    logic [10:0] req_row_s;
    logic        unused_addr_s;

    assign req_row_s     = bus.req_addr[22:12];
    assign unused_addr_s = ^{bus.req_addr[31:23], bus.req_addr[1:0]};

    // Next-state logic, request latching, wait counting and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        row_d   = row_q;
        col_d   = col_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    row_d   = req_row_s;
                    col_d   = bus.req_addr[11:2];
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    // An all-zero strobe write touches nothing, so it is acknowledged directly.
                    if (bus.req_we && (bus.req_wstrb == 4'b0000)) begin
                        state_d = S_RSP;
                    end else if (row_open_q && (open_row_q == req_row_s)) begin
                        state_d = bus.req_we ? S_WR : S_RD;
                    end else if (row_open_q) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_ACT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                state_d = S_PWAIT;
                cnt_d   = RP_LOAD;
            end
            S_PWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACT: begin
                state_d = S_AWAIT;
                cnt_d   = RCD_LOAD;
            end
            S_AWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = we_q ? S_WR : S_RD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD: state_d = S_RWAIT;
            S_RWAIT: begin
                if (DRAM_valid) begin
                    rdata_d = DRAM_Q;
                    state_d = S_RSP;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_WR: begin
                state_d = S_WWAIT;
                cnt_d   = WR_LOAD;
            end
            S_WWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RSP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin and status decode from the next state so the outputs line up with the state register.
    always_comb begin
        csn_d       = 1'b1;
        rasn_d      = 1'b1;
        casn_d      = 1'b1;
        wen_d       = 4'hF;
        a_d         = 11'd0;
        d_d         = 32'd0;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        rsp_valid_d = (state_d == S_RSP);
        req_ready_d = (state_d == S_IDLE);
        case (state_d)
            S_PRE: begin
                csn_d      = 1'b0;
                rasn_d     = 1'b0;
                wen_d      = 4'h0;
                row_open_d = 1'b0;
            end
            S_ACT: begin
                csn_d      = 1'b0;
                rasn_d     = 1'b0;
                a_d        = row_d;
                row_open_d = 1'b1;
                open_row_d = row_d;
            end
            S_RD: begin
                csn_d  = 1'b0;
                casn_d = 1'b0;
                a_d    = {1'b0, col_d};
            end
            S_WR: begin
                csn_d  = 1'b0;
                casn_d = 1'b0;
                wen_d  = ~wstrb_d;
                a_d    = {1'b0, col_d};
                d_d    = wdata_d;
            end
            default: begin
                csn_d = 1'b1;
            end
        endcase
    end

    // State, request, response and pin registers; reset idles the pins and forgets the open row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            row_q       <= 11'd0;
            col_q       <= 10'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rdata_q     <= 32'd0;
            row_open_q  <= 1'b0;
            open_row_q  <= 11'd0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            csn_q       <= 1'b1;
            rasn_q      <= 1'b1;
            casn_q      <= 1'b1;
            wen_q       <= 4'hF;
            a_q         <= 11'd0;
            d_q         <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            csn_q       <= csn_d;
            rasn_q      <= rasn_d;
            casn_q      <= casn_d;
            wen_q       <= wen_d;
            a_q         <= a_d;
            d_q         <= d_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign row_open      = row_open_q;
    assign DRAM_CSn      = csn_q;
    assign DRAM_RASn     = rasn_q;
    assign DRAM_CASn     = casn_q;
    assign DRAM_WEn      = wen_q;
    assign DRAM_A        = a_q;
    assign DRAM_D        = d_q;
endmodule

// File: tb/tb_dram_row_sequencer.sv
// Randomised bench for dram_row_sequencer: a transaction-level model predicts the command
// list (PRE/ACT/RD/WR with NOP gaps) for each request and every cycle is compared against it.
module tb_dram_row_sequencer;
    localparam int T_RP  = 4;
    localparam int T_RCD = 4;
    localparam int T_WR  = 4;

    logic        clk;
    logic        rst;
    logic        row_open;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic        DRAM_valid;
    logic [31:0] DRAM_Q;

    dram_row_sequencer_if bus_if ();

    dram_row_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD), .T_WR(T_WR)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .row_open   (row_open),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_valid (DRAM_valid),
        .DRAM_Q     (DRAM_Q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ro;
        logic        csn;
        logic        rasn;
        logic        casn;
        logic [3:0]  wen;
        logic [10:0] a;
        logic [31:0] d;
        logic        chk_a;
        logic        chk_d;
    } cyc_t;

    cyc_t        seq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        m_open;
    logic [10:0] m_row;
    logic [31:0] m_rdata;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pins_obs();
        return 64'({bus_if.rsp_valid, bus_if.req_ready, row_open,
                    DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn});
    endfunction

    function automatic logic [63:0] pins_exp(input logic rv, input logic rr, input logic ro,
                                             input logic csn, input logic rasn, input logic casn,
                                             input logic [3:0] wen);
        return 64'({rv, rr, ro, csn, rasn, casn, wen});
    endfunction

    task automatic push(input logic ro, input logic csn, input logic rasn, input logic casn,
                        input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d,
                        input logic chk_a, input logic chk_d);
        cyc_t c;
        c = '{ro, csn, rasn, casn, wen, a, d, chk_a, chk_d};
        seq.push_back(c);
    endtask

    task automatic push_nops(input int n);
        for (int k = 0; k < n; k++) push(m_open, 1'b1, 1'b1, 1'b1, 4'hF, 11'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // One request from an idle negedge to the idle negedge after its response handshake.
    // abort_at >= 0 pulls reset at that expected-cycle index instead of completing.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rd_delay, input int hold,
                          input int abort_at, input logic [31:0] q);
        logic [10:0] row;
        logic [9:0]  col;
        row = addr[22:12];
        col = addr[11:2];
        check_eq("idle_pins", pins_obs(), pins_exp(1'b0, 1'b1, m_open, 1'b1, 1'b1, 1'b1, 4'hF));

        seq.delete();
        if (!(we && wstrb == 4'b0000)) begin
            if (!(m_open && m_row == row)) begin
                if (m_open) begin
                    m_open = 1'b0;
                    push(m_open, 1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'd0, 1'b0, 1'b0);
                    push_nops(T_RP);
                end
                m_open = 1'b1;
                m_row  = row;
                push(m_open, 1'b0, 1'b0, 1'b1, 4'hF, row, 32'd0, 1'b1, 1'b0);
                push_nops(T_RCD);
            end
            if (we) begin
                push(m_open, 1'b0, 1'b1, 1'b0, ~wstrb, {1'b0, col}, wdata, 1'b1, 1'b1);
                push_nops(T_WR);
            end else begin
                push(m_open, 1'b0, 1'b1, 1'b0, 4'hF, {1'b0, col}, 32'd0, 1'b1, 1'b0);
            end
        end

        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_wstrb = wstrb;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;

        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                DRAM_valid = 1'b0;
                rst = 1'b0;
                #1;
                check_eq("rst_pins", pins_obs(), pins_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF));
                check_eq("rst_a", 64'(DRAM_A), 64'd0);
                check_eq("rst_rdata", 64'(bus_if.rsp_rdata), 64'd0);
                m_open  = 1'b0;
                m_rdata = 32'd0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            check_eq("cmd_pins", pins_obs(),
                     pins_exp(1'b0, 1'b0, seq[i].ro, seq[i].csn, seq[i].rasn, seq[i].casn, seq[i].wen));
            if (seq[i].chk_a) check_eq("cmd_a", 64'(DRAM_A), 64'(seq[i].a));
            if (seq[i].chk_d) check_eq("cmd_d", 64'(DRAM_D), 64'(seq[i].d));
            // Stray DRAM_valid pulses outside RWAIT must be ignored.
            if (seq[i].csn && $urandom_range(3, 0) == 0) begin
                DRAM_valid = 1'b1;
                DRAM_Q     = $urandom;
            end else begin
                DRAM_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        DRAM_valid = 1'b0;

        if (!we) begin
            for (int k = 0; k <= rd_delay; k++) begin
                check_eq("rwait_pins", pins_obs(),
                         pins_exp(1'b0, 1'b0, m_open, 1'b1, 1'b1, 1'b1, 4'hF));
                if (k == rd_delay) begin
                    DRAM_valid = 1'b1;
                    DRAM_Q     = q;
                    m_rdata    = q;
                end
                @(posedge clk);
                @(negedge clk);
                DRAM_valid = 1'b0;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            check_eq("rsp_pins", pins_obs(), pins_exp(1'b1, 1'b0, m_open, 1'b1, 1'b1, 1'b1, 4'hF));
            check_eq("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(m_rdata));
            if (h == hold) begin
                bus_if.rsp_ready = 1'b1;
                bus_if.req_valid = $urandom_range(1, 0) == 1;
            end
            @(posedge clk);
            @(negedge clk);
            bus_if.rsp_ready = 1'b0;
            bus_if.req_valid = 1'b0;
        end
        check_eq("post_rsp", pins_obs(), pins_exp(1'b0, 1'b1, m_open, 1'b1, 1'b1, 1'b1, 4'hF));
    endtask

    initial begin
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        clk              = 1'b0;
        rst              = 1'b0;
        DRAM_valid       = 1'b0;
        DRAM_Q           = 32'd0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'd0;
        bus_if.req_wdata = 32'd0;
        bus_if.req_wstrb = 4'd0;
        bus_if.rsp_ready = 1'b0;
        m_open           = 1'b0;
        m_row            = 11'd0;
        m_rdata          = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_pins", pins_obs(), pins_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF));
        check_eq("reset_rdata", 64'(bus_if.rsp_rdata), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_txn(1'b0, 32'h0000_1008, 32'd0, 4'd0, 2, 0, -1, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h0000_100C, 32'd0, 4'd0, 0, 1, -1, 32'hCAFE_F00D);
        do_txn(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0011, 0, 5, -1, 32'd0);
        do_txn(1'b1, 32'h0000_3ABC, 32'h5555_AAAA, 4'b0000, 0, 2, -1, 32'd0);
        do_txn(1'b0, 32'h0000_5000, 32'd0, 4'd0, 0, 0, 7, 32'd0);
        do_txn(1'b0, 32'h0000_5000, 32'd0, 4'd0, 1, 0, -1, 32'h0BAD_F00D);

        for (int t = 0; t < 80; t++) begin
            we    = $urandom_range(1, 0) == 1;
            wstrb = ($urandom_range(5, 0) == 0) ? 4'b0000 : 4'($urandom);
            addr  = $urandom;
            addr[22:12] = 11'($urandom_range(3, 0));
            do_txn(we, addr, $urandom, wstrb, $urandom_range(4, 0), $urandom_range(3, 0),
                   ($urandom_range(15, 0) == 0) ? 2 : -1, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
